// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect,
// multi-cycle EX and data-memory wait, with perf counters and a watchdog.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mc_timeout
);

  localparam int TW = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MC_TIMEOUT);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             tout_q, tout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic in_wait;
  logic lu;
  logic mc_stall;
  logic run_free;
  logic sel_frz, sel_mc, sel_rd, sel_lu;

  assign in_wait = (state_q == MC_WAIT);

  assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == id_ex_rd)));

  // A start that completes in the same cycle behaves as a normal op.
  assign mc_stall = in_wait ? !ex_mc_done
                            : (ex_mc_start && !ex_mc_done);
  assign run_free = !in_wait && !ex_mc_start;

  assign sel_frz = !rst && dmem_wait;
  assign sel_mc  = !rst && !dmem_wait && mc_stall;
  assign sel_rd  = !rst && !dmem_wait && run_free && ex_redirect;
  assign sel_lu  = !rst && !dmem_wait && run_free &&
                   !ex_redirect && lu;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    unique case (1'b1)
      rst: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      sel_frz: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
      end
      sel_mc: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end
      sel_rd: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      sel_lu: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tout_d  = tout_q;
    if (in_wait) begin
      if (ex_mc_done && !dmem_wait) state_d = RUN;
      if (tcnt_q != TMAX) tcnt_d = tcnt_q + TW'(1);
      if (tcnt_q + TW'(1) == TMAX) tout_d = 1'b1;
    end else if (ex_mc_start && !ex_mc_done) begin
      state_d = MC_WAIT;
      tcnt_d  = '0;
    end
    stall_d = stall_q + CNT_W'(!pc_en);
    flush_d = flush_q + CNT_W'(sel_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  assign mc_timeout   = tout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios
// followed by constrained-random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read;
  logic        ex_redirect, ex_mc_start, ex_mc_done, dmem_wait;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [31:0] stall_cycles, flush_events;
  logic        mc_timeout;

  pipeline_hazard_ctrl #(.CNT_W(32), .MC_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
    .ex_mc_done(ex_mc_done), .dmem_wait(dmem_wait),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events),
    .mc_timeout(mc_timeout)
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [2:0]  fl;
    logic [31:0] st;
    logic [31:0] fe;
    logic        to;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model: "busy" = an unfinished multi-cycle op is outstanding.
  bit          m_busy;
  int          m_wlen;
  bit          m_flag;
  logic [31:0] m_st, m_fe;

  task automatic model_push();
    exp_t e;
    bit   lu;
    e.st = m_st;
    e.fe = m_fe;
    e.to = m_flag;
    lu = id_ex_mem_read && id_ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == id_ex_rd) ||
          (id_uses_rs2 && id_rs2 == id_ex_rd));
    if (rst) begin
      e.en = 4'b0000; e.fl = 3'b111;
      m_busy = 0; m_wlen = 0; m_flag = 0; m_st = 0; m_fe = 0;
    end else begin
      if (dmem_wait) begin
        e.en = 4'b0000; e.fl = 3'b000;
      end else if (m_busy ? !ex_mc_done : (ex_mc_start && !ex_mc_done)) begin
        e.en = 4'b0001; e.fl = 3'b001;
      end else if (m_busy || ex_mc_start) begin
        e.en = 4'b1111; e.fl = 3'b000;
      end else if (ex_redirect) begin
        e.en = 4'b1111; e.fl = 3'b110; m_fe = m_fe + 1;
      end else if (lu) begin
        e.en = 4'b0011; e.fl = 3'b010;
      end else begin
        e.en = 4'b1111; e.fl = 3'b000;
      end
      if (!e.en[3]) m_st = m_st + 1;
      if (m_busy) begin
        m_wlen++;
        if (m_wlen >= T) m_flag = 1;
        if (ex_mc_done && !dmem_wait) m_busy = 0;
      end else if (ex_mc_start && !ex_mc_done) begin
        m_busy = 1; m_wlen = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic apply(input bit r, input bit mr, input bit [4:0] rd,
                       input bit [4:0] r1, input bit [4:0] r2,
                       input bit u1, input bit u2, input bit rdr,
                       input bit st, input bit dn, input bit dw);
    @(negedge clk);
    #1;
    rst = r; id_ex_mem_read = mr; id_ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_redirect = rdr; ex_mc_start = st; ex_mc_done = dn;
    dmem_wait = dw;
    model_push();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) apply(0,0,0,0,0,0,0,0,0,0,0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({pc_en, if_id_en, id_ex_en, ex_mem_en} !== e.en) begin
          errors++;
          $display("FAIL enables t=%0t got=%b want=%b", $time,
                   {pc_en, if_id_en, id_ex_en, ex_mem_en}, e.en);
        end
        checks++;
        if ({if_id_flush, id_ex_flush, ex_mem_flush} !== e.fl) begin
          errors++;
          $display("FAIL flushes t=%0t got=%b want=%b", $time,
                   {if_id_flush, id_ex_flush, ex_mem_flush}, e.fl);
        end
        checks++;
        if (stall_cycles !== e.st) begin
          errors++;
          $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time,
                   stall_cycles, e.st);
        end
        checks++;
        if (flush_events !== e.fe) begin
          errors++;
          $display("FAIL flush_events t=%0t got=%0d want=%0d", $time,
                   flush_events, e.fe);
        end
        checks++;
        if (mc_timeout !== e.to) begin
          errors++;
          $display("FAIL mc_timeout t=%0t got=%b want=%b", $time,
                   mc_timeout, e.to);
        end
      end
    end
  end

  initial begin : stim
    bit st, mr, rdr;
    rst = 1; id_ex_mem_read = 0; id_ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_redirect = 0;
    ex_mc_start = 0; ex_mc_done = 0; dmem_wait = 0;
    m_busy = 0; m_wlen = 0; m_flag = 0; m_st = 0; m_fe = 0;
    repeat (2) @(posedge clk);

    // reset then release
    apply(1,0,0,0,0,0,0,0,0,0,0);
    apply(1,0,0,0,0,0,0,0,0,0,0);
    nop(2);
    // load-use on rs1, then decode re-evaluated with the load gone
    apply(0,1,5'd5,5'd5,5'd7,1,1,0,0,0,0);
    nop(2);
    // load to x0 never hazards
    apply(0,1,5'd0,5'd0,5'd0,1,1,0,0,0,0);
    nop(1);
    // load-use on rs2 only
    apply(0,1,5'd9,5'd3,5'd9,1,1,0,0,0,0);
    // redirect squashes a concurrent load-use
    apply(0,1,5'd5,5'd5,5'd5,1,1,1,0,0,0);
    nop(2);
    // 4-cycle multi-cycle op
    apply(0,0,0,0,0,0,0,0,1,0,0);
    nop(3);
    apply(0,0,0,0,0,0,0,0,0,1,0);
    nop(2);
    // 1-cycle op
    apply(0,0,0,0,0,0,0,0,1,1,0);
    nop(1);
    // dmem_wait during MC_WAIT, with done held, then advance
    apply(0,0,0,0,0,0,0,0,1,0,0);
    apply(0,0,0,0,0,0,0,0,0,0,1);
    apply(0,0,0,0,0,0,0,0,0,1,1);
    apply(0,0,0,0,0,0,0,0,0,1,1);
    apply(0,0,0,0,0,0,0,0,0,1,0);
    nop(2);
    // timeout, redirect/lu ignored in MC_WAIT, then reset mid-wait
    apply(0,0,0,0,0,0,0,0,1,0,0);
    nop(4);
    apply(0,1,5'd2,5'd2,5'd2,1,1,1,0,0,0);
    nop(T);
    apply(1,0,0,0,0,0,0,0,0,0,0);
    nop(3);

    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 7) == 0);
      mr  = !st && ($urandom_range(0, 2) == 0);
      rdr = !st && ($urandom_range(0, 5) == 0);
      apply($urandom_range(0, 149) == 0, mr,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rdr, st,
            $urandom_range(0, 4) == 0 && !(st && i % 97 < 90),
            $urandom_range(0, 4) == 0);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers from hazard information in decode (load-use), execute (branch/jump redirect, multi-cycle unit), and memory (data-memory wait). Holds a small FSM for multi-cycle EX operations plus stall/flush performance counters and a timeout watchdog.

## Interface
- CNT_W, 32, width of the performance counters.
- MC_TIMEOUT, 64, maximum cycles in MC_WAIT before the `mc_timeout` flag sets.

- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  5  rs1 field of the IF/ID instruction (bits 19:15).
- id_rs2  in  5  rs2 field of the IF/ID instruction (bits 24:20).
- id_uses_rs1, id_uses_rs2  in  1 each  decoded instruction actually reads that source.
- id_ex_rd  in  5  rd held in ID/EX.
- id_ex_mem_read  in  1  the ID/EX instruction is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ex_mc_start  in  1  EX holds a multi-cycle op (mul/div) starting this cycle.
- ex_mc_done  in  1  multi-cycle result valid this cycle.
- dmem_wait  in  1  data memory not ready; MEM stage must hold.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (zero fields) instead of data.
- stall_cycles  out  CNT_W  cycles with `pc_en`=0 since reset.
- flush_events  out  CNT_W  count of redirect flushes since reset.
- mc_timeout  out  1  sticky error: the multi-cycle unit exceeded MC_TIMEOUT.

## Operation
- FSM states are RUN and MC_WAIT. Outputs are combinational from the state and the current inputs. Counters and the flag are registered.
- Load-use hazard (`lu`) is `id_ex_mem_read` && `id_ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`id_ex_rd`) || (`id_uses_rs2` && `id_rs2`==`id_ex_rd`)). The x0 register never hazards.
- Priority is highest first: rst, `dmem_wait`, MC_WAIT, `ex_mc_start`, `ex_redirect`, `lu`, normal.
- rst high: all `*_en`=0, all `*_flush`=1, state RUN, counters 0, `mc_timeout`=0.
- `dmem_wait` (any state): all `*_en`=0, no flushes. Whole front end plus EX/MEM freezes. FSM state, timeout counter and `stall_cycles` increment still apply.
- MC_WAIT, or RUN with `ex_mc_start`:
  - `pc_en`=`if_id_en`=`id_ex_en`=0, `ex_mem_en`=1, `ex_mem_flush`=1 (bubble into MEM).
  - In MC_WAIT with `ex_mc_done`=1: outputs are as normal (all en=1, no flush) so EX/MEM captures the result. Next state is RUN.
  - RUN + `ex_mc_start` goes to MC_WAIT next cycle. `ex_mc_start`&&`ex_mc_done` in the same RUN cycle is a 1-cycle op: treat as normal, stay in RUN.
  - `ex_redirect`, `lu` are ignored while in MC_WAIT.
- `ex_redirect` (RUN): all en=1, `if_id_flush`=1, `id_ex_flush`=1. The PC loads the target. `lu` in the same cycle is squashed, with no stall. `flush_events`+1.
- `lu` (RUN): `pc_en`=`if_id_en`=0, `id_ex_en`=1, `id_ex_flush`=1, `ex_mem_en`=1. Exactly one bubble is inserted, and the next cycle's decode re-evaluates.
- Normal: all en=1, all flush=0.
- `stall_cycles`+1 on every non-reset cycle with `pc_en`=0. `flush_events`+1 on every accepted redirect. Both wrap modulo 2^CNT_W.
- Timeout counter (width ≥ clog2(MC_TIMEOUT+1)):
  - Clears on entering MC_WAIT, increments each MC_WAIT cycle.
  - When it reaches MC_TIMEOUT, `mc_timeout` sets and stays set until rst. The FSM keeps waiting; it never aborts.

## Timing
- Zero-latency control: enables and flushes respond in the same cycle as their inputs.
- Load-use costs exactly 1 stall cycle. A redirect costs 2 flushed slots and no stall.
- An N-cycle multi-cycle op (`ex_mc_done` N cycles after `ex_mc_start`) holds the front end for N cycles. That is N-1 cycles in MC_WAIT plus the start cycle. The pipeline advances on the done cycle.
- `dmem_wait` asserted in the done cycle defers the advance. The FSM stays in MC_WAIT until `ex_mc_done` && !`dmem_wait`; the multi-cycle unit holds done.
- Reset mid-MC_WAIT returns to RUN on the next edge. Outputs take reset values while rst is high.

## Test plan
- Load-use: `id_ex_mem_read`=1, `id_ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 → exactly one cycle of `pc_en`=0, `id_ex_flush`=1, and `stall_cycles`=1. Repeat with rd=0 → no stall.
- Redirect with concurrent `lu` → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, `flush_events`=1, no stall.
- Multi-cycle: `ex_mc_start` at cycle 0, `ex_mc_done` at cycle 4 → `pc_en`=0 in cycles 0-3, `ex_mem_flush`=1 in cycles 0-3, all en=1 in cycle 4, state RUN in cycle 5.
- `dmem_wait` held 3 cycles, during MC_WAIT and with done present → all en=0 for 3 cycles, advance on the first cycle with done && !wait.
- Timeout: MC_TIMEOUT=8, done never asserted → `mc_timeout` rises after 8 MC_WAIT cycles and stays high. Apply rst → clears and state returns to RUN.
- Reset: rst high → all en=0, all flush=1, counters 0. Release → normal outputs in the next cycle.
